stream_demux_1_4: RTL and testbench
===================================

// Module: stream_demux_1_4
// PURPOSE
//   1:4 packet demultiplexer with valid/ready handshake; the counterpart of the 4:1 mux datapath.
//   Routes each input packet, whole and unsplit, to one of four output channels.
//   The channel is chosen by the select value on the first beat of the packet.
//   Each channel has a one-entry output register and a completed-packet counter.
//   Sits between a single producer and four independent consumers.
// PARAMETERS
//   DW  8  data width per beat
//   CW  8  width of each per-channel packet counter
// PORTS
//   clk       in   1       clock; all logic on rising edge
//   rst       in   1       reset, synchronous, active-high
//   in_data   in   DW      input beat data
//   in_sel    in   2       destination channel, used on first beat of a packet only
//   in_last   in   1       marks final beat of a packet
//   in_valid  in   1       input beat valid
//   in_ready  out  1       input beat accepted when in_valid & in_ready
//   out_data  out  4*DW    channel k at [k*DW +: DW]
//   out_last  out  4       per-channel last flag
//   out_valid out  4       per-channel valid
//   out_ready in   4       per-channel ready
//   pkt_cnt   out  4*CW    channel k at [k*CW +: CW]; count of last beats loaded
//   busy      out  1       state==LOCK | (|out_valid)
// BEHAVIOUR
//   Clock and reset
//   - One clock, clk. Reset rst is synchronous and active-high.
//   - Reset values: FSM=IDLE, lock_sel=0, out_valid=0, out_data=0, out_last=0, pkt_cnt=0, busy=0.
//   FSM and destination
//   - dest = in_sel in IDLE; dest = lock_sel in LOCK.
//   - In LOCK, in_sel is ignored.
//   - IDLE: an accepted beat with in_last=0 -> LOCK, and lock_sel<=in_sel.
//   - IDLE: an accepted beat with in_last=1 (single-beat packet) -> stays IDLE.
//   - LOCK: an accepted beat with in_last=1 -> IDLE. Other beats stay in LOCK.
//   Handshake
//   - in_ready = ~out_valid[dest] | out_ready[dest]. This is combinational.
//   - No combinational path from out_ready to any out_* signal.
//   - An input beat sent to a blocked channel stalls the input. Head-of-line blocking is intended.
//     Other channels keep draining.
//   Output register, channel k
//   - An accepted beat with dest==k loads out_data[k] and out_last[k], and sets out_valid[k]=1.
//     Latency is 1 cycle.
//   - out_valid[k] & out_ready[k] with no load: out_valid[k] clears.
//   - Drain and load in the same cycle: the new beat replaces the old one, out_valid stays 1.
//     This gives full throughput of 1 beat per clock.
//   - While out_valid[k] & ~out_ready[k], out_data[k] and out_last[k] hold stable.
//   - While out_valid[k]=0, out_data[k] and out_last[k] keep their last value.
//   Counters
//   - pkt_cnt[k] += 1 when a beat with in_last=1 is accepted for channel k.
//   - Counter is modulo 2^CW: it wraps to 0 with no flag.
//   Reset mid-packet
//   - Partial packet in flight is dropped. FSM returns to IDLE.
//   - The first beat accepted after reset is routed by its own in_sel.
// TESTING
//   1. Single-beat packet, in_sel=2, data=0xA5, last=1, all out_ready=1
//      -> next cycle: out_valid=4'b0100, ch2 data=0xA5, out_last[2]=1, pkt_cnt[2]=1.
//   2. 3-beat packet, in_sel=1 on beat 1, in_sel=3 on beats 2-3
//      -> all 3 beats appear on ch1; out_valid[3] never rises; pkt_cnt[1]=1, pkt_cnt[3]=0.
//   3. out_ready[0]=0, two beats 0x11,0x22 sent to ch0
//      -> 0x11 held stable; in_ready=0 while offering 0x22; raise out_ready[0]
//      -> 0x11 is consumed and 0x22 loads in the same cycle.
//   4. out_ready[0]=1 held, 8 back-to-back beats to ch0
//      -> in_ready stays 1; one beat per cycle out; order preserved; latency 1.
//   5. 256 single-beat packets to ch3 with CW=8 -> pkt_cnt[3] wraps to 0; other counters stay 0.
//   6. rst pulsed after beat 2 of a 4-beat packet to ch1
//      -> next cycle: out_valid=0, busy=0; a next beat with in_sel=2, last=1 lands on ch2.

Source files
------------

// File: rtl/stream_demux_1_4.sv
// stream_demux_1_4: 1:4 packet demultiplexer with valid/ready handshake.
// Each packet is steered whole to one of four registered output channels.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   in_*       single producer stream (data, sel, last, valid / ready)
//   out_*      four consumer streams, channel k at slice k
//   pkt_cnt    per-channel count of completed packets (modulo 2^CW)
//   busy       packet in progress or any output register occupied
module stream_demux_1_4 #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   in_data,
    input  logic [1:0]      in_sel,
    input  logic            in_last,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*DW-1:0] out_data,
    output logic [3:0]      out_last,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*CW-1:0] pkt_cnt,
    output logic            busy
);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      lock_sel_q, lock_sel_d;
    logic [1:0]      dest;
    logic            accept;

    logic [DW-1:0]   data_q  [4];
    logic [DW-1:0]   data_d  [4];
    logic [CW-1:0]   cnt_q   [4];
    logic [CW-1:0]   cnt_d   [4];
    logic [3:0]      last_q, last_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0]      load;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        unique case (state_q)
            IDLE: begin
                // Multi-beat packet: remember its channel for the tail.
                if (accept && !in_last) begin
                    state_d    = LOCK;
                    lock_sel_d = in_sel;
                end
            end
            LOCK: begin
                if (accept && in_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        dest = in_sel;
        busy = |valid_q;
        unique case (state_q)
            IDLE: dest = in_sel;
            LOCK: begin
                dest = lock_sel_q;
                busy = 1'b1;
            end
            default: dest = in_sel;
        endcase
    end

    // Stall only when the target register is full and not draining.
    // out_ready reaches in_ready only, never any out_* signal.
    assign in_ready = ~valid_q[dest] | out_ready[dest];
    assign accept   = in_valid & in_ready;

    // ---------------- per-channel output registers ----------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            load[k]    = accept && (dest == 2'(k));
            data_d[k]  = data_q[k];
            last_d[k]  = last_q[k];
            valid_d[k] = valid_q[k];
            cnt_d[k]   = cnt_q[k];
            if (load[k]) begin
                // A load during a drain simply overwrites: full throughput.
                data_d[k]  = in_data;
                last_d[k]  = in_last;
                valid_d[k] = 1'b1;
                if (in_last) begin
                    cnt_d[k] = cnt_q[k] + CW'(1);
                end
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 4'd0;
            valid_q <= 4'd0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
        end else begin
            last_q  <= last_d;
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    // ---------------- flatten to output buses ----------------
    for (genvar g = 0; g < 4; g++) begin : g_flat
        assign out_data[g*DW +: DW] = data_q[g];
        assign pkt_cnt[g*CW +: CW]  = cnt_q[g];
    end

    assign out_last  = last_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// tb_stream_demux_1_4: directed self-checking bench for stream_demux_1_4.
// Expected values are hand-computed per scenario.
module tb_stream_demux_1_4;

    localparam int DW = 8;
    localparam int CW = 8;

    logic            clk;
    logic            rst;
    logic [DW-1:0]   in_data;
    logic [1:0]      in_sel;
    logic            in_last;
    logic            in_valid;
    logic            in_ready;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_last;
    logic [3:0]      out_valid;
    logic [3:0]      out_ready;
    logic [4*CW-1:0] pkt_cnt;
    logic            busy;

    int n_chk  = 0;
    int n_fail = 0;

    stream_demux_1_4 #(.DW(DW), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pkt_cnt   (pkt_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] dat(input int k);
        return out_data[k*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cnt(input int k);
        return pkt_cnt[k*CW +: CW];
    endfunction

    // Offer one beat, require it to be accepted, step one edge.
    task automatic send(input logic [1:0] s, input logic [DW-1:0] d,
                        input logic l);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        in_last  = l;
        #1;
        check("send_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_sel    = 2'd0;
        in_last   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_valid", out_valid, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_cnt", pkt_cnt, 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_last", out_last, 4'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // 1: single-beat packet to ch2
        send(2'd2, 8'hA5, 1'b1);
        check("t1_valid", out_valid, 4'b0100);
        check("t1_data", dat(2), 8'hA5);
        check("t1_last", out_last[2], 1'b1);
        check("t1_cnt2", cnt(2), 8'd1);
        check("t1_busy", busy, 1'b1);
        idle_cycle();
        check("t1_drained", out_valid, 4'h0);
        check("t1_hold_data", dat(2), 8'hA5);
        check("t1_idle_busy", busy, 1'b0);

        // 2: 3-beat packet locked to ch1 despite in_sel=3 later
        send(2'd1, 8'h31, 1'b0);
        check("t2_b1_valid", out_valid, 4'b0010);
        check("t2_b1_data", dat(1), 8'h31);
        check("t2_b1_last", out_last[1], 1'b0);
        send(2'd3, 8'h32, 1'b0);
        check("t2_b2_valid", out_valid, 4'b0010);
        check("t2_b2_data", dat(1), 8'h32);
        send(2'd3, 8'h33, 1'b1);
        check("t2_b3_valid", out_valid, 4'b0010);
        check("t2_b3_data", dat(1), 8'h33);
        check("t2_b3_last", out_last[1], 1'b1);
        check("t2_cnt1", cnt(1), 8'd1);
        check("t2_cnt3", cnt(3), 8'd0);
        idle_cycle();
        check("t2_drained", out_valid, 4'h0);

        // 3: backpressure on ch0
        out_ready = 4'b1110;
        send(2'd0, 8'h11, 1'b1);
        check("t3_v11", out_valid, 4'b0001);
        check("t3_d11", dat(0), 8'h11);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'h22;
        in_last  = 1'b1;
        #1;
        check("t3_stall", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("t3_hold_data", dat(0), 8'h11);
        check("t3_hold_valid", out_valid, 4'b0001);
        check("t3_stall2", in_ready, 1'b0);
        out_ready = 4'hF;
        #1;
        check("t3_release", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t3_d22", dat(0), 8'h22);
        check("t3_v22", out_valid, 4'b0001);
        check("t3_cnt0", cnt(0), 8'd2);
        idle_cycle();
        check("t3_drained", out_valid, 4'h0);

        // 4: 8 back-to-back beats to ch0, one packet
        for (int i = 0; i < 8; i++) begin
            send(2'd0, 8'(8'h40 + i), (i == 7));
            check("t4_data", dat(0), 64'(8'h40 + i));
            check("t4_valid", out_valid, 4'b0001);
        end
        check("t4_last", out_last[0], 1'b1);
        check("t4_cnt0", cnt(0), 8'd3);
        idle_cycle();

        // 5: 256 single-beat packets to ch3, counter wraps
        for (int i = 0; i < 256; i++) begin
            send(2'd3, 8'(i), 1'b1);
            if (i == 254) check("t5_cnt255", cnt(3), 8'd255);
        end
        check("t5_wrap", cnt(3), 8'd0);
        check("t5_cnt0", cnt(0), 8'd3);
        check("t5_cnt1", cnt(1), 8'd1);
        check("t5_cnt2", cnt(2), 8'd1);
        idle_cycle();

        // 6: reset mid-packet
        send(2'd1, 8'h61, 1'b0);
        send(2'd3, 8'h62, 1'b0);
        check("t6_busy_pre", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_valid", out_valid, 4'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_cnt", pkt_cnt, 32'h0);
        send(2'd2, 8'h5C, 1'b1);
        check("t6_route", out_valid, 4'b0100);
        check("t6_data", dat(2), 8'h5C);
        check("t6_cnt2", cnt(2), 8'd1);
        check("t6_cnt1", cnt(1), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
